cpu_fp_wb_arb: RTL

- Writeback stage directly upstream of the FP register file; drives its single write port (wr_en/wr_addr/wr_data).
- Merges two result producers: the FP load unit (unbuffered, one cycle) and the multi-cycle FPU (buffered in a DEPTH-entry FIFO).
- NaN-boxes single-precision results to 64 bits.
- Exports a per-register pending mask so issue logic can stall on FP RAW hazards.

---
 rtl/cpu_fp_wb_arb.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cpu_fp_wb_arb.sv
// FP writeback arbiter: merges the FP load unit (direct) and the FPU
// (through a DEPTH-entry FIFO) onto the single FP register-file write port.
// Single-precision results are NaN-boxed; a per-register pending mask is
// exported so issue logic can stall on FP RAW hazards.
// Optional feature: define CPU_FP_WB_FLUSH_EN to add the flush input.
module cpu_fp_wb_arb #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef CPU_FP_WB_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [4:0]               ld_addr,
  input  logic [63:0]              ld_data,
  input  logic                     ld_sp,
  input  logic                     fpu_valid,
  output logic                     fpu_ready,
  input  logic [4:0]               fpu_addr,
  input  logic [63:0]              fpu_data,
  input  logic                     fpu_sp,
  output logic                     wr_en,
  output logic [4:0]               wr_addr,
  output logic [63:0]              wr_data,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  // FIFO storage: no reset needed, slot validity is tracked in vld_reg
  logic [4:0]        addr_mem [DEPTH];
  logic [63:0]       data_mem [DEPTH];
  logic [DEPTH-1:0]  vld_reg;
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     cnt_reg;
  logic [SW-1:0]     starve_cnt_reg;
  logic              wr_en_reg;
  logic [4:0]        wr_addr_reg;
  logic [63:0]       wr_data_reg;

  logic              flush_w;
  logic              fifo_empty;
  logic              starve_hit;
  logic              ld_win;
  logic              head_deq;
  logic              enq;
  logic [63:0]       ld_boxed;
  logic [63:0]       fpu_boxed;
  logic [31:0]       slot_mask [DEPTH];

`ifdef CPU_FP_WB_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign fifo_empty = (cnt_reg == '0);
  // Head has lost STARVE_MAX times in a row: load is blocked this cycle
  assign starve_hit = !fifo_empty && (starve_cnt_reg == SW'(STARVE_MAX));

  // Ready signals depend only on registered state (and flush), never on valid
  assign ld_ready  = ~starve_hit & ~flush_w;
  assign fpu_ready = (cnt_reg < CW'(DEPTH)) & ~flush_w;

  assign ld_win   = ld_valid & ld_ready;
  assign head_deq = ~fifo_empty & ~ld_win & ~flush_w;
  assign enq      = fpu_valid & fpu_ready;

  assign ld_boxed  = ld_sp  ? {32'hFFFF_FFFF, ld_data[31:0]}  : ld_data;
  assign fpu_boxed = fpu_sp ? {32'hFFFF_FFFF, fpu_data[31:0]} : fpu_data;

  // FIFO payload write; boxed value is stored so the dequeue path is a plain copy
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wr_ptr_reg] <= fpu_addr;
      data_mem[wr_ptr_reg] <= fpu_boxed;
    end
  end

  // Control state: pointers, occupancy, starvation counter, output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_reg        <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      cnt_reg        <= '0;
      starve_cnt_reg <= '0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
    end else if (flush_w) begin
      vld_reg        <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      cnt_reg        <= '0;
      starve_cnt_reg <= '0;
      wr_en_reg      <= 1'b0;
    end else begin
      // Dequeue clears before enqueue sets; they only share a slot when
      // empty or full, and then only one of them can happen.
      if (head_deq) begin
        vld_reg[rd_ptr_reg] <= 1'b0;
        rd_ptr_reg          <= rd_ptr_reg + 1'b1;
      end
      if (enq) begin
        vld_reg[wr_ptr_reg] <= 1'b1;
        wr_ptr_reg          <= wr_ptr_reg + 1'b1;
      end
      case ({enq, head_deq})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
      if (fifo_empty || head_deq)
        starve_cnt_reg <= '0;
      else if (ld_win)
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
      wr_en_reg <= ld_win | head_deq;
      if (ld_win) begin
        wr_addr_reg <= ld_addr;
        wr_data_reg <= ld_boxed;
      end else if (head_deq) begin
        wr_addr_reg <= addr_mem[rd_ptr_reg];
        wr_data_reg <= data_mem[rd_ptr_reg];
      end
    end
  end

  // Per-slot one-hot destination masks for the pending vector
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign slot_mask[gi] = vld_reg[gi] ? (32'd1 << addr_mem[gi]) : 32'd0;
    end
  endgenerate

  // Pending: output register target plus every valid FIFO entry
  always_comb begin
    pending = wr_en_reg ? (32'd1 << wr_addr_reg) : 32'd0;
    for (int i = 0; i < DEPTH; i++)
      pending = pending | slot_mask[i];
  end

  assign wr_en    = wr_en_reg;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;
  assign fifo_cnt = cnt_reg;

endmodule
